opm_mixer: RTL and testbench

- Downstream consumer of the OPM device sound outputs; replaces the unsaturated combinational sum of per-instance OPM samples.
- On each sample strobe, latches up to COUNT stereo OPM samples and applies a per-source 4-bit gain using one time-shared multiplier per side.
- Outputs saturated 16-bit signed L/R to the system audio mix, with clip and overrun status.

---
 rtl/opm_mixer.sv | 160 ++++++++++++++++
 tb/tb_opm_mixer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opm_mixer.sv
// Stereo mixer for up to four OPM sources: snapshot on sample strobe, per-source
// 4-bit gain through one shared multiplier per side, saturate to 16-bit signed.
module opm_mixer #(
  parameter int unsigned COUNT      = 3,
  parameter int unsigned GAIN_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_ce,
  input  logic [COUNT-1:0]      src_en,
  input  logic [4*COUNT-1:0]    src_vol,
  input  logic [16*COUNT-1:0]   src_L,
  input  logic [16*COUNT-1:0]   src_R,
  input  logic                  clip_clr,
  output logic [15:0]           sound_L,
  output logic [15:0]           sound_R,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  clip,
  output logic                  overrun
);

  localparam int unsigned IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned PW = 21;
  localparam int unsigned AW = PW + $clog2(COUNT);
  localparam logic signed [AW-1:0] SAT_MAX  = AW'(32'sd32767);
  localparam logic signed [AW-1:0] SAT_MIN  = AW'(-32'sd32768);
  localparam logic [IW-1:0]        LAST_IDX = IW'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, LATCH, MAC, SAT} state_t;

  state_t state, state_d;

  logic signed [15:0] snap_l   [COUNT];
  logic signed [15:0] snap_r   [COUNT];
  logic        [3:0]  snap_vol [COUNT];
  logic [COUNT-1:0]   snap_en;

  logic [IW-1:0]        idx, idx_d;
  logic signed [AW-1:0] acc_l, acc_r, acc_l_d, acc_r_d;
  logic signed [AW-1:0] sum_l, sum_r, y_l, y_r;
  logic signed [PW-1:0] gain, prod_l, prod_r;
  logic [15:0]          sat_l, sat_r, sound_l_d, sound_r_d;
  logic                 clamp_l, clamp_r, clamp_hit, clamp_hit_d;
  logic                 out_valid_d, busy_d, clip_d, latch_en, out_load;

  function automatic logic [16:0] saturate(input logic signed [AW-1:0] y);
    if (y > SAT_MAX)      return {1'b1, 16'h7fff};
    else if (y < SAT_MIN) return {1'b1, 16'h8000};
    else                  return {1'b0, y[15:0]};
  endfunction

  // Dropped strobes are flagged in the same cycle they arrive.
  assign overrun = sample_ce & busy;

  // Shared multiply-accumulate; the final sum is saturated on the last MAC cycle
  // so sound_L/R and out_valid update together on entry to SAT.
  always_comb begin
    gain   = PW'($signed({1'b0, snap_vol[idx]}));
    prod_l = snap_en[idx] ? PW'(snap_l[idx]) * gain : '0;
    prod_r = snap_en[idx] ? PW'(snap_r[idx]) * gain : '0;
    sum_l  = acc_l + AW'(prod_l);
    sum_r  = acc_r + AW'(prod_r);
    y_l    = sum_l >>> GAIN_SHIFT;
    y_r    = sum_r >>> GAIN_SHIFT;
    {clamp_l, sat_l} = saturate(y_l);
    {clamp_r, sat_r} = saturate(y_r);
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    acc_l_d  = acc_l;
    acc_r_d  = acc_r;
    busy_d   = busy;
    latch_en = 1'b0;
    out_load = 1'b0;
    case (state)
      IDLE: begin
        if (sample_ce) begin
          state_d = LATCH;
          busy_d  = 1'b1;
        end
      end
      LATCH: begin
        latch_en = 1'b1;
        acc_l_d  = '0;
        acc_r_d  = '0;
        idx_d    = '0;
        state_d  = MAC;
      end
      MAC: begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        if (idx == LAST_IDX) begin
          out_load = 1'b1;
          idx_d    = '0;
          state_d  = SAT;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      SAT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = out_load;
    clamp_hit_d = out_load & (clamp_l | clamp_r);
    sound_l_d   = out_load ? sat_l : sound_L;
    sound_r_d   = out_load ? sat_r : sound_R;
    // A clamp in flight (last MAC or SAT cycle) outranks a simultaneous clear.
    if (clamp_hit_d || (state == SAT && clamp_hit)) clip_d = 1'b1;
    else if (clip_clr)                              clip_d = 1'b0;
    else                                            clip_d = clip;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      sound_L   <= '0;
      sound_R   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      clip      <= 1'b0;
      clamp_hit <= 1'b0;
      snap_en   <= '0;
      for (int i = 0; i < int'(COUNT); i++) begin
        snap_l[i]   <= '0;
        snap_r[i]   <= '0;
        snap_vol[i] <= '0;
      end
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      acc_l     <= acc_l_d;
      acc_r     <= acc_r_d;
      sound_L   <= sound_l_d;
      sound_R   <= sound_r_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      clip      <= clip_d;
      clamp_hit <= clamp_hit_d;
      if (latch_en) begin
        snap_en <= src_en;
        for (int i = 0; i < int'(COUNT); i++) begin
          snap_l[i]   <= src_L[16*i +: 16];
          snap_r[i]   <= src_R[16*i +: 16];
          snap_vol[i] <= src_vol[4*i +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_opm_mixer.sv
// Scoreboard bench for opm_mixer: directed corner cases then random strobes,
// expected mixes computed with integer arithmetic from the latched inputs.
module tb_opm_mixer;

  localparam int COUNT = 3;
  localparam int GS    = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 sample_ce;
  logic [COUNT-1:0]     src_en;
  logic [4*COUNT-1:0]   src_vol;
  logic [16*COUNT-1:0]  src_L, src_R;
  logic                 clip_clr;
  logic [15:0]          sound_L, sound_R;
  logic                 out_valid, busy, clip, overrun;

  opm_mixer #(.COUNT(COUNT), .GAIN_SHIFT(GS)) dut (
    .clk(clk), .reset_n(reset_n), .sample_ce(sample_ce), .src_en(src_en),
    .src_vol(src_vol), .src_L(src_L), .src_R(src_R), .clip_clr(clip_clr),
    .sound_L(sound_L), .sound_R(sound_R), .out_valid(out_valid), .busy(busy),
    .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    int   l;
    int   r;
    logic clip;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   busy_start = 0, busy_end = -1, latch_cyc = 0;
  logic pend = 1'b0, exp_ovr = 1'b0, exp_clip = 1'b0, mon_en = 1'b0;
  int   last_l = 0, last_r = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference mix: gained sum of enabled sources, floor-divided by 2^GS, clamped.
  task automatic push_expect();
    int   sl, sr;
    exp_t e;
    sl = 0;
    sr = 0;
    for (int i = 0; i < COUNT; i++) begin
      if (src_en[i]) begin
        sl += int'($signed(src_L[16*i +: 16])) * int'(src_vol[4*i +: 4]);
        sr += int'($signed(src_R[16*i +: 16])) * int'(src_vol[4*i +: 4]);
      end
    end
    sl = sl >>> GS;
    sr = sr >>> GS;
    if (clamp16(sl) != sl || clamp16(sr) != sr) exp_clip = 1'b1;
    e.cyc  = busy_end;
    e.l    = clamp16(sl);
    e.r    = clamp16(sr);
    e.clip = exp_clip;
    q.push_back(e);
  endtask

  task automatic tick();
    if (pend && cyc == latch_cyc) begin
      push_expect();
      pend = 1'b0;
    end
    @(posedge clk);
    #1;
    sample_ce = 1'b0;
    clip_clr  = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic strobe();
    sample_ce = 1'b1;
    if (cyc > busy_end) begin
      busy_start = cyc + 1;
      busy_end   = cyc + COUNT + 2;
      latch_cyc  = cyc + 1;
      pend       = 1'b1;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic load(input int l0, l1, l2, r0, r1, r2, v0, v1, v2,
                      input logic [2:0] en);
    src_L   = {16'(l2), 16'(l1), 16'(l0)};
    src_R   = {16'(r2), 16'(r1), 16'(r0)};
    src_vol = {4'(v2), 4'(v1), 4'(v0)};
    src_en  = en;
  endtask

  function automatic int rnd_smp();
    if ($urandom % 2 == 0) return int'($signed(16'($urandom)));
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  // Monitor: per-cycle busy/overrun timeline, output pops, hold and reset values.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!reset_n) begin
        chk("rst_sound_L", int'($signed(sound_L)), 0);
        chk("rst_sound_R", int'($signed(sound_R)), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_clip", int'(clip), 0);
        last_l = 0;
        last_r = 0;
      end else begin
        chk("busy", int'(busy), int'(cyc >= busy_start && cyc <= busy_end));
        chk("overrun", int'(overrun), int'(exp_ovr));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("sound_L", int'($signed(sound_L)), e.l);
            chk("sound_R", int'($signed(sound_R)), e.r);
            chk("clip_at_out", int'(clip), int'(e.clip));
            last_l = e.l;
            last_r = e.r;
          end
        end else begin
          chk("sound_L_hold", int'($signed(sound_L)), last_l);
          chk("sound_R_hold", int'($signed(sound_R)), last_r);
          if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missing_out_valid", 0, 1);
            e = q.pop_front();
          end
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    sample_ce = 1'b0;
    clip_clr  = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    // Basic unity-gain mix and latency
    load(1000, 2000, -500, 0, 0, 0, 8, 8, 8, 3'b111);
    strobe();
    repeat (COUNT + 4) tick();

    // Positive clamp, clear, negative clamp
    load(30000, 30000, 0, 100, -100, 50, 8, 8, 8, 3'b111);
    strobe();
    repeat (COUNT + 4) tick();
    clip_clr = 1'b1;
    exp_clip = 1'b0;
    tick();
    chk("clip_cleared", int'(clip), 0);
    load(-30000, -30000, 0, 0, 0, 0, 8, 8, 8, 3'b111);
    strobe();
    repeat (COUNT + 4) tick();

    // Enable mask and floor rounding of negative results
    load(7, 100, 9, 0, -8000, 0, 15, 4, 15, 3'b010);
    strobe();
    repeat (COUNT + 4) tick();
    load(7, -3, 9, 0, 0, 0, 15, 1, 15, 3'b010);
    strobe();
    repeat (COUNT + 4) tick();

    // Strobes during LATCH..SAT are dropped
    load(1234, -4321, 555, 77, 88, 99, 9, 3, 15, 3'b111);
    strobe();
    tick();
    tick();
    strobe();
    repeat (3) tick();
    strobe();
    repeat (4) tick();

    // Inputs changed after LATCH must not affect the result
    load(400, 800, 1200, -400, -800, -1200, 8, 8, 8, 3'b111);
    strobe();
    tick();
    tick();
    load(-9000, 9000, 3, 11, 22, 33, 15, 15, 15, 3'b101);
    repeat (COUNT + 4) tick();

    // Clear coinciding with a clamping SAT: set wins
    clip_clr = 1'b1;
    exp_clip = 1'b0;
    tick();
    chk("clip_cleared2", int'(clip), 0);
    load(30000, 30000, 30000, 0, 0, 0, 15, 15, 15, 3'b111);
    strobe();
    repeat (COUNT + 2) tick();
    clip_clr = 1'b1;
    tick();
    chk("clip_set_wins", int'(clip), 1);
    repeat (2) tick();

    // Reset mid-mix aborts without out_valid
    load(1000, 1000, 1000, 5, 5, 5, 8, 8, 8, 3'b111);
    strobe();
    tick();
    tick();
    reset_n  = 1'b0;
    q.delete();
    pend     = 1'b0;
    busy_end = cyc - 1;
    exp_clip = 1'b0;
    tick();
    chk("abort_sound_L", int'($signed(sound_L)), 0);
    chk("abort_busy", int'(busy), 0);
    reset_n = 1'b1;
    tick();
    load(-2000, 600, 8, 3000, -3000, 16, 8, 12, 1, 3'b111);
    strobe();
    repeat (COUNT + 4) tick();

    // Random traffic with overlapping strobes and input churn
    repeat (400) begin
      if ($urandom % 2 == 0)
        load(rnd_smp(), rnd_smp(), rnd_smp(), rnd_smp(), rnd_smp(), rnd_smp(),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), 3'($urandom));
      if ($urandom % 3 == 0) begin
        strobe();
      end else if (cyc > busy_end && $urandom % 10 == 0) begin
        clip_clr = 1'b1;
        exp_clip = 1'b0;
      end
      tick();
    end

    repeat (COUNT + 4) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
